// File: rtl/c17_out_monitor.sv
// c17_out_monitor: watches the c17 netlist outputs (nx22/nx23) against a
// golden model of the c17 gate network. Counts output transitions and
// post-settle mismatches, and presents them as snapshot registers on request.
// Optional feature macro: C17_MON_GLITCH_EN (glitch counter; tied to 0 when
// undefined).
module c17_out_monitor #(
  parameter int unsigned CNT_W  = 16,
  parameter int unsigned SETTLE = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             nx1,
  input  logic             nx2,
  input  logic             nx3,
  input  logic             nx6,
  input  logic             nx7,
  input  logic             nx22,
  input  logic             nx23,
  input  logic             clr,
  input  logic             snap_req,
  output logic             snap_ack,
  output logic [CNT_W-1:0] tr22,
  output logic [CNT_W-1:0] tr23,
  output logic [CNT_W-1:0] err_cnt,
  output logic [CNT_W-1:0] glitch_cnt,
  output logic             err,
  output logic             busy
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETTLE,
    S_CHECK
  } state_t;

  localparam logic [7:0] SETTLE_LD = 8'(SETTLE);

  state_t           r_state, w_state_nxt;
  logic [7:0]       r_settle, w_settle_nxt;
  logic             w_check;

  logic             r_s22_m, r_s22_s, r_s23_m, r_s23_s;
  logic [4:0]       r_vec, r_vec_prev;
  logic             w_vchg;
  logic             w_t22, w_t23;

  logic             w_n0, w_n1, w_n2, w_n3, w_g22, w_g23;
  logic             w_mismatch;

  logic [CNT_W-1:0] r_tr22, r_tr23, r_err_cnt;
  logic             r_err;
  logic [CNT_W-1:0] w_glitch_live;

  logic [CNT_W-1:0] r_snap_tr22, r_snap_tr23, r_snap_err, r_snap_gl;
  logic             r_ack;

  // Saturating add of a small increment (0..2) to a counter.
  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                               input logic [1:0]       inc);
    logic [CNT_W:0] sum;
    sum = {1'b0, a} + (CNT_W+1)'(inc);
    if (sum[CNT_W]) return '1;
    return sum[CNT_W-1:0];
  endfunction

  // Two-flop synchronizers for the netlist outputs; one register stage for the
  // stimulus vector plus its previous-cycle copy for change detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s22_m    <= 1'b0;
      r_s22_s    <= 1'b0;
      r_s23_m    <= 1'b0;
      r_s23_s    <= 1'b0;
      r_vec      <= '0;
      r_vec_prev <= '0;
    end else begin
      r_s22_m    <= nx22;
      r_s22_s    <= r_s22_m;
      r_s23_m    <= nx23;
      r_s23_s    <= r_s23_m;
      r_vec      <= {nx7, nx6, nx3, nx2, nx1};
      r_vec_prev <= r_vec;
    end
  end

  assign w_vchg = (r_vec != r_vec_prev);
  // A difference across the synchronizer stages means the synchronized value
  // changes at the coming edge; counting then equals counting each change.
  assign w_t22  = r_s22_m ^ r_s22_s;
  assign w_t23  = r_s23_m ^ r_s23_s;

  // Golden c17 model; r_vec = {nx7, nx6, nx3, nx2, nx1}.
  assign w_n1  = ~(r_vec[2] & r_vec[3]);
  assign w_n0  = ~(r_vec[0] & r_vec[2]);
  assign w_n3  = ~(r_vec[1] & w_n1);
  assign w_n2  = ~(r_vec[4] & w_n1);
  assign w_g22 = ~(w_n0 & w_n3);
  assign w_g23 = ~(w_n3 & w_n2);

  // FSM state and settle counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_settle <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_settle <= w_settle_nxt;
    end
  end

  // FSM next-state: wait for a vector change, let it settle, check once.
  always_comb begin
    w_state_nxt  = r_state;
    w_settle_nxt = r_settle;
    w_check      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_vchg) begin
          w_state_nxt  = S_SETTLE;
          w_settle_nxt = SETTLE_LD;
        end
      end
      S_SETTLE: begin
        if (w_vchg) begin
          w_settle_nxt = SETTLE_LD;
        end else if (r_settle <= 8'd1) begin
          w_settle_nxt = '0;
          w_state_nxt  = S_CHECK;
        end else begin
          w_settle_nxt = r_settle - 8'd1;
        end
      end
      S_CHECK: begin
        w_check = 1'b1;
        if (w_vchg) begin
          w_state_nxt  = S_SETTLE;
          w_settle_nxt = SETTLE_LD;
        end else begin
          w_state_nxt  = S_IDLE;
          w_settle_nxt = '0;
        end
      end
      default: begin
        w_state_nxt  = S_IDLE;
        w_settle_nxt = '0;
      end
    endcase
  end

  assign w_mismatch = w_check & ((r_s22_s ^ w_g22) | (r_s23_s ^ w_g23));

  // Live transition/mismatch counters and sticky error flag; clr beats increments.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      r_tr22    <= '0;
      r_tr23    <= '0;
      r_err_cnt <= '0;
      r_err     <= 1'b0;
    end else begin
      r_tr22    <= sat_add(r_tr22, {1'b0, w_t22});
      r_tr23    <= sat_add(r_tr23, {1'b0, w_t23});
      r_err_cnt <= sat_add(r_err_cnt, {1'b0, w_mismatch});
      if (w_mismatch) r_err <= 1'b1;
    end
  end

`ifdef C17_MON_GLITCH_EN
  logic             r_seen22, r_seen23;
  logic             w_in_win;
  logic [1:0]       w_g_inc;
  logic [CNT_W-1:0] r_glitch;

  assign w_in_win = (r_state == S_SETTLE) || (r_state == S_CHECK);
  assign w_g_inc  = {1'b0, w_in_win & w_t22 & r_seen22}
                  + {1'b0, w_in_win & w_t23 & r_seen23};

  // Per-output "already transitioned in this window" flags; the window closes
  // after the CHECK cycle, so flags drop in CHECK and stay low in IDLE.
  always_ff @(posedge clk) begin
    if (rst || r_state == S_IDLE || r_state == S_CHECK) begin
      r_seen22 <= 1'b0;
      r_seen23 <= 1'b0;
    end else begin
      if (w_t22) r_seen22 <= 1'b1;
      if (w_t23) r_seen23 <= 1'b1;
    end
  end

  // Glitch counter: transitions beyond the first per output within a window.
  always_ff @(posedge clk) begin
    if (rst || clr) r_glitch <= '0;
    else            r_glitch <= sat_add(r_glitch, w_g_inc);
  end

  assign w_glitch_live = r_glitch;
`else
  assign w_glitch_live = '0;
`endif

  // Snapshot registers and one-cycle acknowledge; clr forces zeros.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ack       <= 1'b0;
      r_snap_tr22 <= '0;
      r_snap_tr23 <= '0;
      r_snap_err  <= '0;
      r_snap_gl   <= '0;
    end else begin
      r_ack <= snap_req;
      if (clr) begin
        r_snap_tr22 <= '0;
        r_snap_tr23 <= '0;
        r_snap_err  <= '0;
        r_snap_gl   <= '0;
      end else if (snap_req) begin
        r_snap_tr22 <= r_tr22;
        r_snap_tr23 <= r_tr23;
        r_snap_err  <= r_err_cnt;
        r_snap_gl   <= w_glitch_live;
      end
    end
  end

  assign snap_ack   = r_ack;
  assign tr22       = r_snap_tr22;
  assign tr23       = r_snap_tr23;
  assign err_cnt    = r_snap_err;
  assign glitch_cnt = r_snap_gl;
  assign err        = r_err;
  assign busy       = (r_state != S_IDLE);

endmodule

// File: doc/c17_out_monitor.md
C17_OUT_MONITOR -- requirements
Module: c17_out_monitor

Interface
REQ-001 Parameter CNT_W, default 16, width of every counter output.
REQ-002 Parameter SETTLE, default 4, cycles of stable input vector before outputs are checked (legal range 1..255).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 nx1, nx2, nx3, nx6, nx7  input  1 each  stimulus vector driven to the c17 netlist, already in the clk domain.
REQ-006 nx22, nx23  input  1 each  c17 netlist outputs, asynchronous to clk (delay-model timing).
REQ-007 clr  input  1  one-cycle pulse, clears all counters and err.
REQ-008 snap_req  input  1  one-cycle pulse requesting a counter snapshot.
REQ-009 snap_ack  output  1  one-cycle pulse, snapshot outputs valid.
REQ-010 tr22, tr23  output  CNT_W each  snapshot of output transition counts.
REQ-011 err_cnt  output  CNT_W  snapshot of mismatch count.
REQ-012 glitch_cnt  output  CNT_W  snapshot of glitch count (see Configuration).
REQ-013 err  output  1  sticky live flag, set on first mismatch.
REQ-014 busy  output  1  high while FSM is not in IDLE.

Function
REQ-015 nx22/nx23 pass through a 2-flop synchronizer; the stimulus vector is registered once; all logic uses the synchronized/registered copies.
REQ-016 Golden model: n1=~(nx3&nx6), n0=~(nx1&nx3), n3=~(nx2&n1), n2=~(nx7&n1), g22=~(n0&n3), g23=~(n3&n2), evaluated on the registered vector.
REQ-017 Each synchronized 0->1 or 1->0 change of nx22 (nx23) increments the live tr22 (tr23) counter by 1.
REQ-018 All counters saturate at 2^CNT_W-1; no wrap-around.
REQ-019 FSM states IDLE, SETTLE, CHECK.
REQ-020 IDLE -> SETTLE when the registered vector differs from its previous-cycle value; settle counter loaded with SETTLE.
REQ-021 SETTLE: counter decrements each cycle; a further vector change reloads it and stays in SETTLE; on reaching 0 -> CHECK.
REQ-022 CHECK (one cycle): compare synchronized outputs with g22/g23; any bit mismatch increments live err_cnt by 1 and sets err; then -> IDLE, or -> SETTLE if the vector changed in that cycle.
REQ-023 Snapshot: on snap_req, live counters copied to output registers; snap_ack high the following cycle for exactly one cycle; output registers otherwise hold.
REQ-024 snap_req while snap_ack is high is accepted and produces a second snapshot and ack.
REQ-025 clr clears live counters, err, and output registers next cycle; clr and an increment in the same cycle: clr wins; clr and snap_req together: snapshot captures zeros.
REQ-026 clr does not change FSM state.

Reset
REQ-027 rst high at a clock edge: FSM -> IDLE, settle counter 0, all counters 0, err 0, snap_ack 0, busy 0, all output registers 0, synchronizer and vector registers 0.
REQ-028 rst mid-SETTLE aborts the pending check with no err_cnt update; rst dominates clr and snap_req.
REQ-029 First vector change after reset is detected against the all-zero reset vector.

Configuration
REQ-030 Macro C17_MON_GLITCH_EN defined: glitch counter increments by 1 for every synchronized output transition beyond the first on the same output within one SETTLE window (SETTLE entry through CHECK); saturating, cleared by clr/rst, snapshotted like the others.
REQ-031 Macro undefined: glitch logic absent, glitch_cnt tied to 0.

Verification
REQ-032 Reset, all inputs 0, outputs nx22=0 nx23=0, snapshot -> tr22=0, tr23=0, err_cnt=0, err=0.
REQ-033 Vector nx1=1 nx3=1 others 0, nx22 driven 0->1 2 cycles later, nx23=0 -> after SETTLE+sync, no mismatch, snapshot tr22=1, err_cnt=0.
REQ-034 Same vector with nx22 held 0 -> CHECK increments err_cnt to 1, err=1; snapshot err_cnt=1.
REQ-035 Vector changes every 2 cycles for 10 cycles with SETTLE=4 -> FSM never reaches CHECK, err_cnt stays 0, busy high throughout.
REQ-036 clr and tr22 increment in same cycle, then snap_req -> tr22=0, snap_ack pulse exactly one cycle.
REQ-037 With C17_MON_GLITCH_EN: nx22 toggles 0->1->0->1 within one window -> glitch_cnt=2; without macro glitch_cnt=0.
